// File: rtl/ram_burst_reader.sv
// Read-side burst sequencer for a synchronous-read block RAM.
// Walks a contiguous address range and streams the words out through a 2-entry valid/ready buffer.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done_tick,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic [1:0]            count_q, count_d;

  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;

  // Occupancy the buffer would have after this edge if nothing new were issued.
  assign pop   = (count_q != 2'd0) && m_ready;
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == RUN) && (remaining_q != '0) && (occ < 3'd2);

  // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    r_addr_d    = r_addr_q;
    remaining_d = remaining_q;
    inflight_d  = 1'b0;
    tag_d       = tag_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;
    count_d     = count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            r_addr_d    = base_addr;
            remaining_d = len;
            busy_d      = 1'b1;
            state_d     = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue && (remaining_q == (ADDR_WIDTH+1)'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        // Finish at the edge that pops the final word so done_tick follows it directly.
        if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      r_addr_d    = r_addr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
      inflight_d  = 1'b1;
      tag_d       = (remaining_q == (ADDR_WIDTH+1)'(1));
    end

    case ({inflight_q, pop})
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          data0_d = q;
          last0_d = tag_q;
        end else begin
          data1_d = q;
          last1_d = tag_q;
        end
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          data0_d = q;
          last0_d = tag_q;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = q;
          last1_d = tag_q;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      r_addr_q    <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      tag_q       <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      r_addr_q    <= r_addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      count_q     <= count_d;
    end
  end

  assign busy      = busy_q;
  assign done_tick = done_q;
  assign r_addr    = r_addr_q;
  assign m_data    = data0_q;
  assign m_valid   = (count_q != 2'd0);
  assign m_last    = (count_q != 2'd0) && last0_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a synchronous-read RAM model and a stream collector.
module tb_ram_burst_reader;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, start, m_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done_tick, m_valid, m_last;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] q, m_data;

  logic [DW-1:0] mem [0:DEPTH-1];

  always #5 clk = ~clk;

  // RAM model: address registered on the edge, data visible the following cycle.
  always @(posedge clk) q <= mem[r_addr];

  ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done_tick(done_tick), .r_addr(r_addr), .q(q),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] rx_data [$];
  logic          rx_last [$];
  int            rdy_mode = 0;
  int            bp_stall = 0;
  logic          bp_tog = 1'b1;
  logic          chk_occ = 1'b0;
  logic          prev_stall = 1'b0;
  logic          prev_full_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [AW-1:0] prev_raddr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive m_ready, check stall invariants, collect transfers, advance to #1 after the edge.
  task automatic step();
    case (rdy_mode)
      1: m_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (rx_data.size() < 2) m_ready = 1'b1;
        else if (bp_stall < 5) begin
          m_ready = 1'b0;
          bp_stall++;
        end else begin
          m_ready = bp_tog;
          bp_tog  = ~bp_tog;
        end
      end
      default: ;
    endcase
    if (prev_stall) begin
      check("stall_valid", m_valid, 1);
      check("stall_data", m_data, prev_data);
      check("stall_last", m_last, prev_last);
    end
    if (prev_full_stall) check("raddr_frozen", r_addr, prev_raddr);
    if (chk_occ) check("occupancy_le2", (dut.count_q <= 2'd2), 1);
    if (m_valid && m_ready) begin
      rx_data.push_back(m_data);
      rx_last.push_back(m_last);
    end
    prev_stall      = m_valid && !m_ready;
    prev_data       = m_data;
    prev_last       = m_last;
    prev_full_stall = chk_occ && (dut.count_q == 2'd2) && !m_ready;
    prev_raddr      = r_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done_tick && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done"}, done_tick, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    step();
    check({tag, "_done_pulse"}, done_tick, 0);
  endtask

  task automatic check_words(input int base, input int n, input string tag);
    check({tag, "_count"}, rx_data.size(), n);
    for (int i = 0; i < n && i < rx_data.size(); i++) begin
      check({tag, "_data"}, rx_data[i], mem[(base + i) % DEPTH]);
      check({tag, "_last"}, rx_last[i], (i == n - 1));
    end
  endtask

  task automatic run_burst(input int base, input int n, input int mode, input int budget,
                           input string tag);
    rx_data.delete();
    rx_last.delete();
    base_addr = AW'(base);
    len       = (AW+1)'(n);
    start     = 1'b1;
    rdy_mode  = mode;
    step();
    start = 1'b0;
    wait_done(budget, tag);
    rdy_mode = 0;
    m_ready  = 1'b1;
    check_words(base, n, tag);
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = (a < 16) ? DW'(a + 8'h10) : '0;
    reset = 1'b1; start = 1'b0; m_ready = 1'b1; base_addr = '0; len = '0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done_tick, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    check("rst_raddr", r_addr, 0);
    reset = 1'b0;
    step();

    // Basic burst with exact cycle timing
    rx_data.delete(); rx_last.delete();
    base_addr = 10'd4; len = 11'd4; start = 1'b1;
    step();
    start = 1'b0;
    check("basic_busy", busy, 1);
    check("basic_valid_e0", m_valid, 0);
    step();
    check("basic_valid_e1", m_valid, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("basic_valid", m_valid, 1);
      check("basic_data", m_data, 8'h14 + i);
      check("basic_last", m_last, (i == 3));
      step();
    end
    check("basic_done", done_tick, 1);
    check("basic_busy_low", busy, 0);
    check("basic_valid_end", m_valid, 0);
    step();
    check("basic_done_pulse", done_tick, 0);

    // Address wrap
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a);
    base_addr = 10'd1022; len = 11'd4; start = 1'b1;
    step();
    start = 1'b0;
    check("wrap_addr0", r_addr, 10'd1022);
    step();
    check("wrap_addr1", r_addr, 10'd1023);
    step();
    check("wrap_addr2", r_addr, 10'd0);
    check("wrap_data0", m_data, 8'hFE);
    step();
    check("wrap_addr3", r_addr, 10'd1);
    check("wrap_data1", m_data, 8'hFF);
    step();
    check("wrap_data2", m_data, 8'h00);
    step();
    check("wrap_data3", m_data, 8'h01);
    check("wrap_last", m_last, 1);
    wait_done(10, "wrap");

    // Backpressure
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a * 3 + 1);
    bp_stall = 0; bp_tog = 1'b1; chk_occ = 1'b1;
    run_burst(0, 8, 2, 200, "bp");
    chk_occ = 1'b0;

    // Zero length
    base_addr = 10'd7; len = 11'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("zero_done", done_tick, 1);
    check("zero_busy", busy, 0);
    check("zero_valid", m_valid, 0);
    step();
    check("zero_done_pulse", done_tick, 0);
    check("zero_valid2", m_valid, 0);

    // Start ignored while busy
    rx_data.delete(); rx_last.delete();
    base_addr = 10'd0; len = 11'd6; start = 1'b1;
    step();
    start = 1'b0;
    step();
    base_addr = 10'd100; len = 11'd3; start = 1'b1;
    step();
    start = 1'b0;
    check("ign_busy", busy, 1);
    wait_done(50, "ign");
    check_words(0, 6, "ign");
    check("ign_raddr_end", r_addr, 10'd6);

    // Full memory with random backpressure
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a * 7 + 3);
    run_burst(5, 1024, 1, 8000, "full");
    if (rx_data.size() == 1024) check("full_final_word", rx_data[1023], mem[4]);
    else check("full_size", rx_data.size(), 1024);

    // Reset mid-burst
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a);
    rx_data.delete(); rx_last.delete();
    m_ready = 1'b1;
    base_addr = 10'd0; len = 11'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid_third_word", m_data, 8'h02);
    check("mid_third_valid", m_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    prev_stall = 1'b0;
    check("mid_valid", m_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_raddr", r_addr, 0);
    check("mid_done", done_tick, 0);
    step();
    check("mid_done2", done_tick, 0);
    check("mid_valid2", m_valid, 0);
    run_burst(0, 2, 0, 20, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
